ssm_mux_word_demux: RTL and testbench
=====================================

// Module: ssm_mux_word_demux
// PURPOSE
//  Upstream feeder of the per-substream bit-parser (SSM) funnel shifters. Accepts the serial
//  stream of 128-bit mux words from the bitstream input, routes each word to the substream
//  that requested it (VDC-M mux-word order), and buffers words in per-SSM show-ahead FIFOs.
//  Each SSM pops via its codec_data_rd_en; every pop issues one new request into a global
//  request-order queue.
// PARAMETERS
//  NUM_SSM     4    number of substreams
//  WORD_W      128  mux word width (bits)
//  FIFO_DEPTH  4    words per SSM FIFO; power of 2, >=2
//  INIT_WORDS  2    words pre-requested per SSM at slice start; 1..FIFO_DEPTH
// PORTS
//  clk             in   1               clock; all state on rising edge
//  rst             in   1               asynchronous, active-high reset
//  slice_start     in   1               pulse: flush everything, begin new slice
//  bs_data         in   WORD_W          incoming mux word
//  bs_valid        in   1               bs_data valid
//  bs_ready        out  1               word accepted when bs_valid & bs_ready
//  ssm_rd_en       in   NUM_SSM         per-SSM pop (codec_data_rd_en of each parser)
//  ssm_data        out  NUM_SSM*WORD_W  FIFO head per SSM; SSM i at [i*WORD_W +: WORD_W]
//  ssm_data_vld    out  NUM_SSM         FIFO i non-empty
//  underflow_err   out  1               sticky: pop seen on an empty FIFO
//  state_o         out  2               0=IDLE 1=INIT 2=RUN (debug)
// BEHAVIOUR
//  - Reset (async, active-high): state IDLE; FIFOs, request queue, pointers and counters
//    cleared. Outputs: bs_ready=0, ssm_data=0, ssm_data_vld=0, underflow_err=0.
//  - FSM:
//    IDLE -> INIT on slice_start.
//    INIT loads one request per cycle in round-robin order (SSM0..SSM{N-1}, repeated
//    INIT_WORDS times). It lasts NUM_SSM*INIT_WORDS cycles, then moves to RUN.
//    RUN persists until the next slice_start.
//  - slice_start in any state, including mid-RUN or mid-INIT:
//    next cycle, all FIFOs, the queue and underflow_err are cleared; state = INIT.
//    A bs handshake in the same cycle is dropped.
//    Pops in the same cycle are ignored.
//  - Request queue: depth NUM_SSM*FIFO_DEPTH, entries are SSM indices.
//    In RUN, every valid pop (ssm_rd_en[i] & ssm_data_vld[i]) appends index i.
//    Multiple pops in one cycle append in ascending index order, all in that cycle.
//    By construction, outstanding requests per SSM never exceed FIFO_DEPTH minus occupancy.
//    Queue overflow is therefore impossible; an implementation assertion checks it.
//  - bs_ready = (state==RUN) & queue non-empty. A combinational function of registered
//    state only; it must not depend on bs_valid.
//  - On handshake: bs_data is written to FIFO[queue head] and the head is popped.
//    If the same cycle also appends requests, both apply; count = old + pushes - 1.
//  - Latency: a word accepted at cycle t appears on ssm_data/ssm_data_vld at t+1.
//  - FIFOs are show-ahead: ssm_data[i] shows the head while vld=1 and is 0 while empty.
//    Same-cycle push and pop on one FIFO is legal. Occupancy is unchanged and the head
//    advances.
//  - A pop on an empty FIFO (ssm_rd_en[i] & ~ssm_data_vld[i]) is ignored, logs no
//    request, and sets underflow_err. underflow_err is cleared only by rst or slice_start.
//  - Pops in IDLE/INIT are ignored (FIFOs are empty there); they also set underflow_err.
//  - Pointer widths are log2(FIFO_DEPTH) with wrap-around. Occupancy counters are
//    log2(FIFO_DEPTH)+1 bits.
// TESTING
//  1. rst, then slice_start; bs_valid held high with words W0..W7, no pops.
//     -> INIT lasts 8 cycles. W0,W4 go to SSM0; W1,W5 to SSM1; W2,W6 to SSM2; W3,W7 to SSM3.
//     -> bs_ready drops after W7; all ssm_data_vld=4'b1111.
//  2. After 1: pop SSM2 only, then present W8.
//     -> W8 goes to SSM2 and appears one cycle after acceptance.
//     -> SSM2 head = W6 immediately after the pop.
//  3. After 1: pop SSM3 and SSM1 in the same cycle; present W8, W9.
//     -> W8 goes to SSM1, W9 to SSM3 (ascending index order).
//  4. Pop SSM0 three times with no bs input.
//     -> Heads W0, W4, then vld[0]=0.
//     -> underflow_err=1 on the third pop; no extra request logged; queue count = 2.
//  5. slice_start mid-RUN with 3 pending requests and non-empty FIFOs.
//     -> Next cycle: vld=0, underflow_err=0, state=INIT.
//     -> After 8 cycles, routing restarts at SSM0.
//  6. Assert rst mid-transfer with bs_valid=1.
//     -> Asynchronously: bs_ready=0, ssm_data_vld=0, state=IDLE.
//     -> No word is routed until the next slice_start/INIT completes.

Source files
------------

// File: rtl/ssm_mux_word_demux.sv
// ssm_mux_word_demux
// Routes the serial stream of mux words to the substream parsers in the order they
// requested them. Each substream has a show-ahead FIFO. Every pop from a FIFO
// queues one new request. A slice start pre-loads INIT_WORDS requests per
// substream in round-robin order.
module ssm_mux_word_demux #(
   parameter int unsigned NUM_SSM    = 4,
   parameter int unsigned WORD_W     = 128,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned INIT_WORDS = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      slice_start,
   input  logic [WORD_W-1:0]         bs_data,
   input  logic                      bs_valid,
   output logic                      bs_ready,
   input  logic [NUM_SSM-1:0]        ssm_rd_en,
   output logic [NUM_SSM*WORD_W-1:0] ssm_data,
   output logic [NUM_SSM-1:0]        ssm_data_vld,
   output logic                      underflow_err,
   output logic [1:0]                state_o
);

   localparam int unsigned PW         = $clog2(FIFO_DEPTH);
   localparam int unsigned CW         = PW + 1;
   localparam int unsigned QDEPTH     = NUM_SSM * FIFO_DEPTH;
   localparam int unsigned QPW        = $clog2(QDEPTH);
   localparam int unsigned QCW        = QPW + 1;
   localparam int unsigned SW         = (NUM_SSM > 1) ? $clog2(NUM_SSM) : 1;
   localparam int unsigned INIT_TOTAL = NUM_SSM * INIT_WORDS;
   localparam int unsigned IW         = $clog2(INIT_TOTAL + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_INIT = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     init_cnt_q;
   logic [SW-1:0]     init_ssm_q;
   logic              init_last;

   // Per-substream FIFO storage and bookkeeping
   logic [WORD_W-1:0] fifo_mem [NUM_SSM][FIFO_DEPTH];
   logic [PW-1:0]     f_rd_ptr [NUM_SSM];
   logic [PW-1:0]     f_wr_ptr [NUM_SSM];
   logic [CW-1:0]     f_cnt    [NUM_SSM];
   logic [NUM_SSM-1:0] f_vld;
   logic [NUM_SSM-1:0] f_push;
   logic [NUM_SSM-1:0] pop_ok;

   // Global request-order queue of substream indices
   logic [SW-1:0]     q_mem    [QDEPTH];
   logic [QPW-1:0]    q_rd_ptr;
   logic [QPW-1:0]    q_wr_ptr;
   logic [QCW-1:0]    q_cnt;
   logic [QCW:0]      q_cnt_sum;
   logic [QPW-1:0]    q_slot   [NUM_SSM];
   logic [QCW-1:0]    n_push;
   logic [NUM_SSM-1:0] req_vec;
   logic [SW-1:0]     q_head;
   logic              hs;
   logic              uf_hit;

   // Wrap a queue position that may have run one lap past the end
   function automatic logic [QPW-1:0] q_wrap(input logic [QCW-1:0] v);
      logic [QCW-1:0] r;
      r = (v >= QCW'(QDEPTH)) ? (v - QCW'(QDEPTH)) : v;
      return r[QPW-1:0];
   endfunction

   assign init_last = (init_cnt_q == IW'(INIT_TOTAL - 1));
   assign state_o   = state_q;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic: slice_start restarts INIT from any state
   always_comb begin
      state_d = state_q;
      if (slice_start) begin
         state_d = ST_INIT;
      end else begin
         case (state_q)
            ST_INIT: if (init_last) state_d = ST_RUN;
            default: state_d = state_q;
         endcase
      end
   end

   // INIT sequencing: total request count and round-robin substream index
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         init_cnt_q <= '0;
         init_ssm_q <= '0;
      end else if (slice_start) begin
         init_cnt_q <= '0;
         init_ssm_q <= '0;
      end else if (state_q == ST_INIT) begin
         init_cnt_q <= init_last ? '0 : init_cnt_q + IW'(1);
         init_ssm_q <= (init_ssm_q == SW'(NUM_SSM - 1)) ? '0 : init_ssm_q + SW'(1);
      end
   end

   // Handshake, pop qualification and underflow detection
   always_comb begin
      for (int unsigned i = 0; i < NUM_SSM; i++) begin
         f_vld[i] = (f_cnt[i] != '0);
      end
      q_head   = q_mem[q_rd_ptr];
      bs_ready = (state_q == ST_RUN) && (q_cnt != '0);
      hs       = bs_valid & bs_ready & ~slice_start;
      pop_ok   = ssm_rd_en & f_vld & {NUM_SSM{(state_q == ST_RUN) & ~slice_start}};
      uf_hit   = |(ssm_rd_en & ~f_vld);
      for (int unsigned i = 0; i < NUM_SSM; i++) begin
         f_push[i] = hs && (q_head == SW'(i));
      end
   end

   // Requests to append this cycle and the queue slot each one lands in;
   // lower indices take earlier slots so same-cycle pops keep ascending order
   always_comb begin
      req_vec = '0;
      if (!slice_start) begin
         if (state_q == ST_INIT) req_vec[init_ssm_q] = 1'b1;
         else if (state_q == ST_RUN) req_vec = pop_ok;
      end
      n_push = '0;
      for (int unsigned i = 0; i < NUM_SSM; i++) begin
         q_slot[i] = q_wrap({1'b0, q_wr_ptr} + n_push);
         if (req_vec[i]) n_push = n_push + QCW'(1);
      end
      q_cnt_sum = {1'b0, q_cnt} + {1'b0, n_push} - (QCW + 1)'(hs);
   end

   // Request queue pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_rd_ptr <= '0;
         q_wr_ptr <= '0;
         q_cnt    <= '0;
      end else if (slice_start) begin
         q_rd_ptr <= '0;
         q_wr_ptr <= '0;
         q_cnt    <= '0;
      end else begin
         q_cnt    <= q_cnt_sum[QCW-1:0];
         q_wr_ptr <= q_wrap({1'b0, q_wr_ptr} + n_push);
         if (hs) q_rd_ptr <= q_wrap({1'b0, q_rd_ptr} + QCW'(1));
      end
   end

   // Request queue storage
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_SSM; i++) begin
         if (req_vec[i]) q_mem[q_slot[i]] <= SW'(i);
      end
   end

   // FIFO pointers and occupancy; push and pop together leave the count unchanged
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_SSM; i++) begin
            f_rd_ptr[i] <= '0;
            f_wr_ptr[i] <= '0;
            f_cnt[i]    <= '0;
         end
      end else if (slice_start) begin
         for (int unsigned i = 0; i < NUM_SSM; i++) begin
            f_rd_ptr[i] <= '0;
            f_wr_ptr[i] <= '0;
            f_cnt[i]    <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_SSM; i++) begin
            if (f_push[i]) f_wr_ptr[i] <= f_wr_ptr[i] + PW'(1);
            if (pop_ok[i]) f_rd_ptr[i] <= f_rd_ptr[i] + PW'(1);
            f_cnt[i] <= f_cnt[i] + CW'(f_push[i]) - CW'(pop_ok[i]);
         end
      end
   end

   // FIFO word storage
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < NUM_SSM; i++) begin
         if (f_push[i]) fifo_mem[i][f_wr_ptr[i]] <= bs_data;
      end
   end

   // Show-ahead heads, forced to zero while a FIFO is empty
   always_comb begin
      ssm_data = '0;
      for (int unsigned i = 0; i < NUM_SSM; i++) begin
         if (f_vld[i]) ssm_data[i*WORD_W +: WORD_W] = fifo_mem[i][f_rd_ptr[i]];
      end
      ssm_data_vld = f_vld;
   end

   // Sticky underflow flag, cleared only by reset or a new slice
   always_ff @(posedge clk or posedge rst) begin
      if (rst)              underflow_err <= 1'b0;
      else if (slice_start) underflow_err <= 1'b0;
      else if (uf_hit)      underflow_err <= 1'b1;
   end

   // Outstanding requests are bounded by FIFO space, so the queue cannot overflow
   a_queue_no_overflow: assert property (
      @(posedge clk) disable iff (rst) q_cnt_sum <= (QCW + 1)'(QDEPTH));

endmodule

// File: tb/tb_ssm_mux_word_demux.sv
// Testbench for ssm_mux_word_demux: constant-expectation vector table, directed
// multi-cycle sequences and randomized traffic, all compared against a
// queue-based reference model of request order and per-substream FIFOs.
module tb_ssm_mux_word_demux;
   localparam int N = 4;
   localparam int W = 128;
   typedef logic [W-1:0] word_t;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           slice_start = 1'b0;
   word_t          bs_data = '0;
   logic           bs_valid = 1'b0;
   logic           bs_ready;
   logic [N-1:0]   ssm_rd_en = '0;
   logic [N*W-1:0] ssm_data;
   logic [N-1:0]   ssm_data_vld;
   logic           underflow_err;
   logic [1:0]     state_o;

   int checks = 0;
   int errors = 0;

   ssm_mux_word_demux #(
      .NUM_SSM(N), .WORD_W(W), .FIFO_DEPTH(4), .INIT_WORDS(2)
   ) dut (
      .clk(clk), .rst(rst), .slice_start(slice_start),
      .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(bs_ready),
      .ssm_rd_en(ssm_rd_en), .ssm_data(ssm_data), .ssm_data_vld(ssm_data_vld),
      .underflow_err(underflow_err), .state_o(state_o)
   );

   always #5 clk = ~clk;

   // Reference model: 0=IDLE 1=INIT 2=RUN, request order queue, FIFO contents
   word_t m_fifo [N][$];
   int    m_req[$];
   int    m_state;
   int    m_init;
   bit    m_uf;

   function automatic word_t wd(input int k);
      word_t w;
      w = {32'hC0DE_0000 + 32'(k), 64'h0123_4567_89AB_CDEF, 32'(k)};
      return w;
   endfunction

   function automatic word_t lane(input int i);
      return ssm_data[i*W +: W];
   endfunction

   task automatic chk(input string name, input word_t got, input word_t exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic void model_clear();
      for (int i = 0; i < N; i++) m_fifo[i].delete();
      m_req.delete();
      m_init = 0;
      m_uf = 1'b0;
   endfunction

   function automatic void model_reset();
      model_clear();
      m_state = 0;
   endfunction

   function automatic void model_update(input bit ss, input bit bv, input word_t bd,
                                        input logic [N-1:0] rd);
      int newr[$];
      int t;
      if (ss) begin
         model_clear();
         m_state = 1;
         return;
      end
      for (int i = 0; i < N; i++)
         if (rd[i] && m_fifo[i].size() == 0) m_uf = 1'b1;
      if (m_state == 1) begin
         m_req.push_back(m_init % N);
         m_init++;
         if (m_init == N * 2) m_state = 2;
      end else if (m_state == 2) begin
         for (int i = 0; i < N; i++) begin
            if (rd[i] && m_fifo[i].size() > 0) begin
               void'(m_fifo[i].pop_front());
               newr.push_back(i);
            end
         end
         if (bv && m_req.size() > 0) begin
            t = m_req.pop_front();
            m_fifo[t].push_back(bd);
         end
         foreach (newr[k]) m_req.push_back(newr[k]);
      end
   endfunction

   task automatic check_model();
      chk("m_ready", W'(bs_ready), W'(m_state == 2 && m_req.size() > 0));
      for (int i = 0; i < N; i++) begin
         chk($sformatf("m_vld%0d", i), W'(ssm_data_vld[i]), W'(m_fifo[i].size() > 0));
         chk($sformatf("m_data%0d", i), lane(i),
             (m_fifo[i].size() > 0) ? m_fifo[i][0] : word_t'(0));
      end
      chk("m_uf", W'(underflow_err), W'(m_uf));
      chk("m_state", W'(state_o), W'(m_state));
   endtask

   // Called at a falling edge: check, drive for the next rising edge, advance model
   task automatic step(input bit ss, input bit bv, input word_t bd, input logic [N-1:0] rd);
      check_model();
      slice_start = ss;
      bs_valid    = bv;
      bs_data     = bd;
      ssm_rd_en   = rd;
      model_update(ss, bv, bd, rd);
      @(negedge clk);
      slice_start = 1'b0;
      bs_valid    = 1'b0;
      ssm_rd_en   = '0;
   endtask

   task automatic fill(input bit init_pop);
      step(1, 0, '0, '0);
      step(0, 0, '0, init_pop ? 4'b0001 : 4'b0000);
      repeat (7) step(0, 0, '0, '0);
      for (int k = 0; k < 8; k++) step(0, 1, wd(k), '0);
   endtask

   typedef struct {
      bit         ss;
      bit         bv;
      int         wi;
      logic [N-1:0] rd;
      bit         e_rdy;
      logic [N-1:0] e_vld;
      bit         e_uf;
      logic [1:0] e_st;
      int         hd0;
   } vec_t;
   vec_t tv[$];

   function automatic void add(input bit ss, input bit bv, input int wi, input logic [N-1:0] rd,
                               input bit rdy, input logic [N-1:0] vld, input bit uf,
                               input logic [1:0] st, input int hd0);
      vec_t v;
      v.ss = ss; v.bv = bv; v.wi = wi; v.rd = rd;
      v.e_rdy = rdy; v.e_vld = vld; v.e_uf = uf; v.e_st = st; v.hd0 = hd0;
      tv.push_back(v);
   endfunction

   initial begin
      logic [N-1:0] vseq [8];
      vseq = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};

      // Slice fill with W0..W7 then three SSM0 pops and a refill of two words
      add(1, 0, 0, 4'b0000, 0, 4'b0000, 0, 2'd0, -1);
      for (int k = 0; k < 8; k++) add(0, 1, 0, 4'b0000, 0, 4'b0000, 0, 2'd1, -1);
      for (int k = 0; k < 8; k++) add(0, 1, k, 4'b0000, 1, vseq[k], 0, 2'd2, (k == 1) ? 0 : -1);
      add(0, 0, 0,  4'b0000, 0, 4'b1111, 0, 2'd2, -1);
      add(0, 0, 0,  4'b0001, 0, 4'b1111, 0, 2'd2, 0);
      add(0, 0, 0,  4'b0001, 1, 4'b1111, 0, 2'd2, 4);
      add(0, 0, 0,  4'b0001, 1, 4'b1110, 0, 2'd2, -1);
      add(0, 1, 8,  4'b0000, 1, 4'b1110, 1, 2'd2, -1);
      add(0, 1, 9,  4'b0000, 1, 4'b1111, 1, 2'd2, 8);
      add(0, 1, 10, 4'b0000, 0, 4'b1111, 1, 2'd2, -1);
      add(0, 0, 0,  4'b0000, 0, 4'b1111, 1, 2'd2, 8);

      repeat (2) @(negedge clk);
      chk("rst_ready", W'(bs_ready), W'(0));
      chk("rst_vld", W'(ssm_data_vld), W'(0));
      chk("rst_data", ssm_data[W-1:0], '0);
      chk("rst_uf", W'(underflow_err), W'(0));
      chk("rst_state", W'(state_o), W'(0));
      rst = 1'b0;
      model_reset();

      foreach (tv[k]) begin
         chk($sformatf("tv%0d_ready", k), W'(bs_ready), W'(tv[k].e_rdy));
         chk($sformatf("tv%0d_vld", k), W'(ssm_data_vld), W'(tv[k].e_vld));
         chk($sformatf("tv%0d_uf", k), W'(underflow_err), W'(tv[k].e_uf));
         chk($sformatf("tv%0d_state", k), W'(state_o), W'(tv[k].e_st));
         if (tv[k].hd0 >= 0) chk($sformatf("tv%0d_head0", k), lane(0), wd(tv[k].hd0));
         step(tv[k].ss, tv[k].bv, wd(tv[k].wi), tv[k].rd);
      end

      // Pop SSM2 twice, refill: W8 lands in SSM2 one cycle after acceptance
      fill(0);
      step(0, 0, '0, 4'b0100);
      chk("s2_head_w6", lane(2), wd(6));
      step(0, 0, '0, 4'b0100);
      chk("s2_empty_vld", W'(ssm_data_vld[2]), W'(0));
      chk("s2_empty_data", lane(2), '0);
      step(0, 1, wd(8), '0);
      chk("s2_w8_vld", W'(ssm_data_vld[2]), W'(1));
      chk("s2_w8_data", lane(2), wd(8));

      // Same-cycle pops of SSM3 and SSM1 request in ascending index order
      fill(0);
      step(0, 0, '0, 4'b1010);
      chk("s3_head1_w5", lane(1), wd(5));
      chk("s3_head3_w7", lane(3), wd(7));
      step(0, 1, wd(8), '0);
      step(0, 1, wd(9), '0);
      step(0, 0, '0, 4'b1010);
      chk("s3_head1_w8", lane(1), wd(8));
      chk("s3_head3_w9", lane(3), wd(9));

      // slice_start mid-RUN with pending requests, a handshake and a pop in the same cycle
      fill(1);
      chk("s5_uf_before", W'(underflow_err), W'(1));
      step(0, 0, '0, 4'b0111);
      step(1, 1, wd(20), 4'b1000);
      chk("s5_vld", W'(ssm_data_vld), W'(0));
      chk("s5_uf", W'(underflow_err), W'(0));
      chk("s5_state", W'(state_o), W'(1));
      repeat (8) step(0, 1, wd(20), '0);
      step(0, 1, wd(21), '0);
      chk("s5_route_vld", W'(ssm_data_vld), W'(4'b0001));
      chk("s5_route_data", lane(0), wd(21));

      // Asynchronous reset in the middle of a transfer
      step(1, 0, '0, '0);
      repeat (8) step(0, 0, '0, '0);
      for (int k = 0; k < 3; k++) step(0, 1, wd(40 + k), '0);
      bs_valid = 1'b1;
      bs_data  = wd(30);
      #2 rst = 1'b1;
      #1;
      chk("s6_ready", W'(bs_ready), W'(0));
      chk("s6_vld", W'(ssm_data_vld), W'(0));
      chk("s6_state", W'(state_o), W'(0));
      @(negedge clk);
      rst = 1'b0;
      bs_valid = 1'b0;
      model_reset();
      repeat (4) step(0, 1, wd(31), '0);
      chk("s6_idle_vld", W'(ssm_data_vld), W'(0));
      step(1, 1, wd(31), '0);
      repeat (8) step(0, 1, wd(31), '0);
      step(0, 1, wd(32), '0);
      chk("s6_route_data", lane(0), wd(32));

      // Randomized traffic against the model
      step(1, 0, '0, '0);
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, wd(100 + c),
              N'($urandom) & N'($urandom));
      end
      check_model();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
